phy_rx_sched: RTL
=================

Name: phy_rx_sched

Overview:
Ingress scheduler that chooses which of the four PHY receive FIFOs the MAC frame decoder services next. It replaces a fixed-priority scheme with three urgency levels, round-robin within each level, and anti-starvation aging. It exchanges a request/grant/ack/done handshake with the decoder and runs a watchdog on every granted frame. It sits between the four PHY FIFO status outputs and the decoder's IDLE state.

Parameters:
AGE_W, 4, width of each per-port age counter
AGE_MAX, 15, age value at which a port is promoted to starved level; must be <= 2^AGE_W-1 and >= 1
WDOG_W, 16, width of busy watchdog counter
WDOG_MAX, 16'hFFFF, busy cycles without done before timeout

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
port_en  in  4  per-port enable (config, clk domain); disabled ports are never candidates
frame_exist  in  4  complete frame present per FIFO (clk domain)
afull_async  in  4  FIFO almost-full, write-clock domain
half_async  in  4  FIFO half-full, write-clock domain
req  in  1  decoder idle and ready for a grant
gnt_valid  out  1  grant offered
gnt_id  out  2  granted port
gnt_level  out  2  urgency level of grant: 3 starved, 2 afull, 1 half, 0 frame_exist
gnt_ack  in  1  decoder accepts grant
done  in  1  decoder finished the granted frame (1-cycle pulse)
busy  out  1  grant accepted, frame in progress
wdog_timeout  out  1  1-cycle pulse when the watchdog expires

Behaviour:
- Reset: all outputs 0; state S_IDLE; last_gnt=3 (so port 0 is first in round-robin); age counters 0; watchdog 0; sync flops 0.
- afull_async/half_async each pass through a 2-FF synchronizer (afull_s, half_s), giving 2-cycle latency. frame_exist and port_en are used directly.
- Candidate[i] = port_en[i] & (frame_exist[i] | half_s[i] | afull_s[i]).
- Level[i]: 3 if candidate & age[i]==AGE_MAX; else 2 if afull_s; else 1 if half_s; else 0.
- Winner: highest level among candidates. Ties are broken round-robin, searching last_gnt+1, +2, +3, +4 modulo 4. The winner is combinational.
- Register updates (gnt_id, gnt_level, age, last_gnt, watchdog) occur only at the transitions listed below.
- S_IDLE: if req & any candidate, register gnt_id/gnt_level from the winner, set gnt_valid=1, and go to S_GRANT. gnt_valid is asserted the cycle after req is sampled.
- S_GRANT: gnt_id and gnt_level are held stable while gnt_valid=1.
  - gnt_ack=1: gnt_valid<=0, busy<=1, last_gnt<=gnt_id, watchdog<=0, go to S_BUSY.
  - Age update on ack, using candidate flags sampled that cycle: age[gnt_id]<=0. Every other candidate port increments, saturating at AGE_MAX. Non-candidate ports hold.
  - req=0 without ack: withdraw. gnt_valid<=0, go to S_IDLE; no age or round-robin update.
  - ack and req=0 in the same cycle: ack wins.
- S_BUSY: watchdog increments each cycle.
  - done=1: busy<=0, go to S_IDLE.
  - watchdog==WDOG_MAX without done: wdog_timeout=1 for one cycle, busy<=0, go to S_IDLE.
  - done in the same cycle as expiry: done wins, no timeout.
- done outside S_BUSY and gnt_ack outside S_GRANT are ignored.
- A port disabled via port_en mid-frame does not abort S_BUSY; it only affects future arbitration.
- A candidate dropping while in S_GRANT does not revoke the grant; the decoder handles the empty FIFO.
- Earliest re-grant after done is 2 cycles later (S_IDLE, then S_GRANT).
- An illegal state encoding recovers to S_IDLE with all outputs 0.
- arst_n asserted mid-operation returns every register to its reset value immediately.

Test Plan:
- frame_exist=4'b1111, all others 0, req held, ack immediately, done 5 cycles later, repeated 8 times -> gnt_id sequence 0,1,2,3,0,1,2,3; gnt_level=0 throughout.
- frame_exist=4'b0011, afull_async=4'b0100 -> gnt_id=2, gnt_level=2; the grant appears only ≥2 cycles after afull_async rises (sync latency).
- half_async[1]=1 continuously plus frame_exist[3]=1, AGE_MAX=3, port 1 re-granted each round -> port 3 age reaches 3 after 3 grants; 4th grant is gnt_id=3, gnt_level=3; age[3] then reads 0.
- Grant offered, req dropped before ack -> gnt_valid falls the next cycle; the following arbitration gives the same gnt_id (last_gnt unchanged).
- Ack then no done, WDOG_MAX=20 -> wdog_timeout pulses exactly 1 cycle after 21 busy cycles, busy=0, state idle; a second test with done on the expiry cycle shows no pulse.
- port_en=4'b1110 with frame_exist=4'b0001 -> no gnt_valid ever; reset asserted during S_BUSY -> busy=0, gnt_valid=0 immediately.

Source files
------------

// File: rtl/phy_rx_sched.sv
// Ingress scheduler for four PHY receive FIFOs: three urgency levels, round-robin within a level,
// age-based starvation promotion, and a watchdog on every frame handed to the MAC decoder.
module phy_rx_sched #(
    parameter int unsigned          AGE_W    = 4,
    parameter int unsigned          AGE_MAX  = 15,
    parameter int unsigned          WDOG_W   = 16,
    parameter logic [WDOG_W-1:0]    WDOG_MAX = 16'hFFFF
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [3:0] port_en,
    input  logic [3:0] frame_exist,
    input  logic [3:0] afull_async,
    input  logic [3:0] half_async,
    input  logic       req,
    output logic       gnt_valid,
    output logic [1:0] gnt_id,
    output logic [1:0] gnt_level,
    input  logic       gnt_ack,
    input  logic       done,
    output logic       busy,
    output logic       wdog_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        afull_meta_q, afull_s_q;
    logic [3:0]        half_meta_q, half_s_q;
    logic              gnt_valid_q, gnt_valid_d;
    logic [1:0]        gnt_id_q, gnt_id_d;
    logic [1:0]        gnt_level_q, gnt_level_d;
    logic              busy_q, busy_d;
    logic              wdog_timeout_q, wdog_timeout_d;
    logic [1:0]        last_gnt_q, last_gnt_d;
    logic [AGE_W-1:0]  age_q [4];
    logic [AGE_W-1:0]  age_d [4];
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    logic [3:0]        cand;
    logic [1:0]        level [4];
    logic [1:0]        max_level;
    logic [1:0]        win_id;
    logic [1:0]        idx;
    logic              win_found;

    // Fill levels come from the FIFO write clock, so they are resynchronised before use.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            afull_meta_q <= '0;
            afull_s_q    <= '0;
            half_meta_q  <= '0;
            half_s_q     <= '0;
        end else begin
            afull_meta_q <= afull_async;
            afull_s_q    <= afull_meta_q;
            half_meta_q  <= half_async;
            half_s_q     <= half_meta_q;
        end
    end

    always_comb begin
        cand      = port_en & (frame_exist | half_s_q | afull_s_q);
        max_level = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (cand[i] && (age_q[i] == AGE_LIM)) begin
                level[i] = 2'd3;
            end else if (afull_s_q[i]) begin
                level[i] = 2'd2;
            end else if (half_s_q[i]) begin
                level[i] = 2'd1;
            end else begin
                level[i] = 2'd0;
            end
            if (cand[i] && (level[i] > max_level)) begin
                max_level = level[i];
            end
        end
        // Search starts just after the last granted port; k=4 wraps back onto it.
        win_id    = last_gnt_q;
        win_found = 1'b0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_gnt_q + 2'(k);
            if (!win_found && cand[idx] && (level[idx] == max_level)) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_valid_d    = gnt_valid_q;
        gnt_id_d       = gnt_id_q;
        gnt_level_d    = gnt_level_q;
        busy_d         = busy_q;
        wdog_timeout_d = 1'b0;
        last_gnt_d     = last_gnt_q;
        age_d          = age_q;
        wdog_d         = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (req && (|cand)) begin
                    gnt_id_d    = win_id;
                    gnt_level_d = max_level;
                    gnt_valid_d = 1'b1;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                if (gnt_ack) begin
                    gnt_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    last_gnt_d  = gnt_id_q;
                    wdog_d      = '0;
                    state_d     = S_BUSY;
                    for (int i = 0; i < 4; i++) begin
                        if (2'(i) == gnt_id_q) begin
                            age_d[i] = '0;
                        end else if (cand[i] && (age_q[i] < AGE_LIM)) begin
                            age_d[i] = age_q[i] + AGE_W'(1);
                        end
                    end
                end else if (!req) begin
                    gnt_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_BUSY: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (done) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (wdog_q == WDOG_MAX) begin
                    wdog_timeout_d = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                gnt_valid_d = 1'b0;
                gnt_id_d    = 2'd0;
                gnt_level_d = 2'd0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= S_IDLE;
            gnt_valid_q    <= 1'b0;
            gnt_id_q       <= 2'd0;
            gnt_level_q    <= 2'd0;
            busy_q         <= 1'b0;
            wdog_timeout_q <= 1'b0;
            last_gnt_q     <= 2'd3;
            wdog_q         <= '0;
            for (int i = 0; i < 4; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            gnt_valid_q    <= gnt_valid_d;
            gnt_id_q       <= gnt_id_d;
            gnt_level_q    <= gnt_level_d;
            busy_q         <= busy_d;
            wdog_timeout_q <= wdog_timeout_d;
            last_gnt_q     <= last_gnt_d;
            wdog_q         <= wdog_d;
            for (int i = 0; i < 4; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign gnt_valid    = gnt_valid_q;
    assign gnt_id       = gnt_id_q;
    assign gnt_level    = gnt_level_q;
    assign busy         = busy_q;
    assign wdog_timeout = wdog_timeout_q;

endmodule
